// File: rtl/grid_pkg.sv
// rtl/grid_pkg.sv - shared grid geometry, reader state enum and FIFO entry type
package grid_pkg;

  localparam int GRID_SIZE  = 28;
  localparam int GRID_CELLS = GRID_SIZE * GRID_SIZE;
  localparam int ADDR_W     = 10;
  localparam int COORD_W    = 5;
  localparam int PIXEL_W    = 8;
  localparam logic [PIXEL_W-1:0] PIXEL_ON = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [PIXEL_W-1:0] pixel;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
    logic               last;
  } fifo_entry_t;

endpackage

// File: rtl/grid_stream_reader_if.sv
// rtl/grid_stream_reader_if.sv - grid memory read port plus pixel stream bundle
interface grid_stream_reader_if;
  import grid_pkg::*;

  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic               rd_data;
  logic               out_valid;
  logic               out_ready;
  logic [PIXEL_W-1:0] out_pixel;
  logic [COORD_W-1:0] out_row;
  logic [COORD_W-1:0] out_col;
  logic               out_last;

  modport master (
    output rd_en, rd_addr, out_valid, out_pixel, out_row, out_col, out_last,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_en, rd_addr, out_valid, out_pixel, out_row, out_col, out_last,
    output rd_data, out_ready
  );

endinterface

// File: rtl/grid_skid_fifo.sv
// rtl/grid_skid_fifo.sv - two-entry FIFO with a registered head entry
module grid_skid_fifo
  import grid_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        clear,
  input  logic        push,
  input  fifo_entry_t push_data,
  input  logic        pop,
  output fifo_entry_t head,
  output logic [1:0]  count,
  output logic        not_empty
);

  fifo_entry_t head_q, head_d;
  fifo_entry_t tail_q, tail_d;
  logic [1:0]  count_q, count_d;

  // Next head/tail/count; the head always holds the oldest entry so the output never goes through a read mux.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear) begin
      head_d  = '0;
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_d  = push_data;
            count_d = 2'd1;
          end else if (count_q == 2'd1) begin
            tail_d  = push_data;
            count_d = 2'd2;
          end
        end
        2'b01: begin
          if (count_q == 2'd2) begin
            head_d  = tail_q;
            count_d = 2'd1;
          end else if (count_q == 2'd1) begin
            count_d = 2'd0;
          end
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            head_d = tail_q;
            tail_d = push_data;
          end else begin
            head_d  = push_data;
            count_d = 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage registers, cleared asynchronously so the stream fields read zero out of reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head      = head_q;
  assign count     = count_q;
  assign not_empty = (count_q != 2'd0);

endmodule

// File: rtl/grid_stream_reader.sv
// rtl/grid_stream_reader.sv - streams the frozen 28x28 grid as tagged 8-bit pixels
module grid_stream_reader #(
  parameter int                    GRID_SIZE = grid_pkg::GRID_SIZE,
  parameter int                    PIXEL_W   = grid_pkg::PIXEL_W,
  parameter logic [PIXEL_W-1:0]    PIXEL_ON  = grid_pkg::PIXEL_ON,
  parameter int                    ADDR_W    = grid_pkg::ADDR_W
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        start,
  input  logic                        abort,
  output logic                        busy,
  output logic                        done,
  grid_stream_reader_if.master        bus
);
  import grid_pkg::*;

  localparam logic [COORD_W-1:0] LAST_IDX  = COORD_W'(GRID_SIZE - 1);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(GRID_CELLS - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic [COORD_W-1:0] rd_row_q, rd_row_d, rd_col_q, rd_col_d;
  logic [COORD_W-1:0] wr_row_q, wr_row_d, wr_col_q, wr_col_d;
  logic               inflight_q, inflight_d;
  logic               rd_en, push, pop, credit_ok, frame_go;
  logic [1:0]         fifo_count;
  logic               fifo_valid;
  logic [PIXEL_W-1:0] pixel_val;
  fifo_entry_t        push_entry, head;

  assign pop       = fifo_valid && bus.out_ready;
  assign push      = inflight_q && !abort;
  assign frame_go  = (state_q == ST_IDLE) && start && !abort;
  // A new read is allowed only if it still fits after everything already owed to the FIFO lands.
  assign credit_ok = ({1'b0, fifo_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

  // FSM next state, read strobe and read-side counters; abort overrides everything.
  always_comb begin
    state_d   = state_q;
    rd_en     = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_row_d  = rd_row_q;
    rd_col_d  = rd_col_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_FETCH;
      ST_FETCH: begin
        rd_en = credit_ok;
        if (rd_en && (rd_addr_q == LAST_ADDR)) state_d = ST_DRAIN;
      end
      ST_DRAIN: ;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (pop && head.last && (state_q == ST_FETCH || state_q == ST_DRAIN)) state_d = ST_DONE;
    if (rd_en) begin
      rd_addr_d = rd_addr_q + ADDR_W'(1);
      if (rd_col_q == LAST_IDX) begin
        rd_col_d = '0;
        rd_row_d = rd_row_q + COORD_W'(1);
      end else begin
        rd_col_d = rd_col_q + COORD_W'(1);
      end
    end
    if (frame_go) begin
      rd_addr_d = '0;
      rd_row_d  = '0;
      rd_col_d  = '0;
    end
    if (abort) begin
      state_d   = ST_IDLE;
      rd_en     = 1'b0;
      rd_addr_d = '0;
      rd_row_d  = '0;
      rd_col_d  = '0;
    end
  end

  assign inflight_d = rd_en;

  // Write-side coordinate tags advance with each returning cell, independent of the read counters.
  always_comb begin
    wr_row_d = wr_row_q;
    wr_col_d = wr_col_q;
    if (push) begin
      if (wr_col_q == LAST_IDX) begin
        wr_col_d = '0;
        wr_row_d = wr_row_q + COORD_W'(1);
      end else begin
        wr_col_d = wr_col_q + COORD_W'(1);
      end
    end
    if (frame_go || abort) begin
      wr_row_d = '0;
      wr_col_d = '0;
    end
  end

  assign pixel_val        = bus.rd_data ? PIXEL_ON : '0;
  assign push_entry.pixel = pixel_val;
  assign push_entry.row   = wr_row_q;
  assign push_entry.col   = wr_col_q;
  assign push_entry.last  = (wr_row_q == LAST_IDX) && (wr_col_q == LAST_IDX);

  // State, counters and the in-flight flag; reset behaves like an asynchronous abort.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      rd_addr_q  <= '0;
      rd_row_q   <= '0;
      rd_col_q   <= '0;
      wr_row_q   <= '0;
      wr_col_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      rd_row_q   <= rd_row_d;
      rd_col_q   <= rd_col_d;
      wr_row_q   <= wr_row_d;
      wr_col_q   <= wr_col_d;
      inflight_q <= inflight_d;
    end
  end

  grid_skid_fifo u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .clear     (abort),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .not_empty (fifo_valid)
  );

  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.out_valid = fifo_valid;
  assign bus.out_pixel = head.pixel;
  assign bus.out_row   = head.row;
  assign bus.out_col   = head.col;
  assign bus.out_last  = head.last;
  assign busy          = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_grid_stream_reader.sv
// tb/tb_grid_stream_reader.sv - scoreboard bench for grid_stream_reader
module tb_grid_stream_reader;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, done;

  grid_stream_reader_if bus();

  grid_stream_reader dut (
    .clock  (clock),
    .resetn (resetn),
    .start  (start),
    .abort  (abort),
    .busy   (busy),
    .done   (done),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  bit mem [0:783];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int e0 = 0;
  logic [18:0] exp_q [$];

  int xfers, stalls, first_rel, last_rel, dones, done_rel, wraps;
  int occ = 0;
  bit tb_infl = 1'b0;
  bit prev_stall = 1'b0;
  bit have_prev = 1'b0;
  logic [18:0] stall_fields;
  logic [4:0] prev_row, prev_col;
  logic [18:0] cur, expv;
  bit popv;
  int rel;

  // synchronous read port of the grid memory
  always @(posedge clock) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

  always @(posedge clock) cyc <= cyc + 1;

  // scoreboard and occupancy model, sampled mid-cycle
  always @(negedge clock) begin
    if (!resetn) begin
      occ = 0; tb_infl = 0; prev_stall = 0; have_prev = 0;
    end else begin
      rel = cyc - e0;
      popv = bus.out_valid && bus.out_ready;
      cur = {bus.out_pixel, bus.out_row, bus.out_col, bus.out_last};
      n_checks++;
      if (bus.out_valid !== (occ != 0)) begin
        n_fail++; $display("FAIL out_valid_occ rel=%0d got %b required %b", rel, bus.out_valid, occ != 0);
      end
      if (bus.rd_en) begin
        n_checks++;
        if (occ + int'(tb_infl) - int'(popv) >= 2) begin
          n_fail++; $display("FAIL credit rel=%0d occ=%0d infl=%0d pop=%0d", rel, occ, tb_infl, popv);
        end
      end
      if (prev_stall) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || cur !== stall_fields) begin
          n_fail++; $display("FAIL stall_stable rel=%0d got %h required %h", rel, cur, stall_fields);
        end
      end
      if (popv) begin
        xfers++;
        if (first_rel < 0) first_rel = rel;
        if (bus.out_last) last_rel = rel;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL unexpected_xfer rel=%0d got %h required none", rel, cur);
        end else begin
          expv = exp_q.pop_front();
          if (cur !== expv) begin
            n_fail++; $display("FAIL pixel rel=%0d got %h required %h", rel, cur, expv);
          end
        end
        if (have_prev && prev_col == 5'd27) begin
          wraps++;
          n_checks++;
          if (bus.out_col !== 5'd0 || int'(bus.out_row) != int'(prev_row) + 1) begin
            n_fail++; $display("FAIL wrap rel=%0d got r%0d c%0d required r%0d c0", rel, bus.out_row, bus.out_col, prev_row + 1);
          end
        end
        have_prev = 1; prev_row = bus.out_row; prev_col = bus.out_col;
      end
      if (bus.out_valid && !bus.out_ready) stalls++;
      if (done) begin
        dones++; done_rel = rel;
        n_checks++;
        if (busy !== 1'b0) begin
          n_fail++; $display("FAIL done_busy rel=%0d got %b required 0", rel, busy);
        end
      end
      if (abort) begin
        occ = 0; tb_infl = 0; prev_stall = 0; have_prev = 0;
      end else begin
        occ = occ + int'(tb_infl) - int'(popv);
        tb_infl = bus.rd_en;
        prev_stall = bus.out_valid && !bus.out_ready;
        stall_fields = cur;
      end
    end
  end

  task automatic fill_mem(input bit diag);
    for (int k = 0; k < 784; k++) mem[k] = diag && (k % 29 == 0);
  endtask

  task automatic reset_stats();
    xfers = 0; stalls = 0; first_rel = -1; last_rel = -1;
    dones = 0; done_rel = -1; wraps = 0; have_prev = 0;
  endtask

  task automatic start_frame();
    for (int k = 0; k < 784; k++)
      exp_q.push_back({(k / 28 == k % 28) && mem[k] ? 8'd255 : 8'd0, 5'(k / 28), 5'(k % 28), k == 783});
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0; e0 = cyc;
  endtask

  task automatic run_frame(input bit rand_ready, input int restart_at, output int done_at);
    done_at = -1;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clock); #1;
      bus.out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      start = (restart_at >= 0) && (cyc - e0 == restart_at);
      @(negedge clock);
      if (done) begin
        done_at = cyc - e0;
        break;
      end
    end
    start = 1'b0;
    @(posedge clock); #1;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({bus.out_valid, busy, done, bus.rd_en, bus.rd_addr, bus.out_pixel, bus.out_row, bus.out_col, bus.out_last} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got v%b b%b d%b r%b a%0d p%0d", bus.out_valid, busy, done, bus.rd_en, bus.rd_addr, bus.out_pixel);
    end
    @(posedge clock); #1 resetn = 1'b1;
    repeat (3) @(posedge clock); #1;
    n_checks++;
    if ({bus.out_valid, busy, bus.rd_en} !== 3'b000) begin
      n_fail++; $display("FAIL idle_after_reset got v%b b%b r%b required 000", bus.out_valid, busy, bus.rd_en);
    end
  endtask

  task automatic test_diag_full_rate();
    int d;
    fill_mem(1); reset_stats(); bus.out_ready = 1'b1;
    start_frame();
    n_checks++;
    if ({busy, bus.rd_en} !== 2'b11 || bus.rd_addr !== 10'd0) begin
      n_fail++; $display("FAIL cycle0 got busy=%b rd_en=%b addr=%0d required 1 1 0", busy, bus.rd_en, bus.rd_addr);
    end
    run_frame(1'b0, -1, d);
    n_checks++; if (d != 786) begin n_fail++; $display("FAIL diag_done_cycle got %0d required 786", d); end
    n_checks++; if (first_rel != 2) begin n_fail++; $display("FAIL diag_first got %0d required 2", first_rel); end
    n_checks++; if (last_rel != 785) begin n_fail++; $display("FAIL diag_last got %0d required 785", last_rel); end
    n_checks++; if (xfers != 784) begin n_fail++; $display("FAIL diag_xfers got %0d required 784", xfers); end
    n_checks++; if (dones != 1) begin n_fail++; $display("FAIL diag_dones got %0d required 1", dones); end
  endtask

  task automatic test_random_stall();
    int d;
    fill_mem(1); reset_stats(); bus.out_ready = 1'b1;
    start_frame();
    run_frame(1'b1, -1, d);
    n_checks++; if (d != 786 + stalls) begin n_fail++; $display("FAIL stall_done_cycle got %0d required %0d", d, 786 + stalls); end
    n_checks++; if (xfers != 784) begin n_fail++; $display("FAIL stall_xfers got %0d required 784", xfers); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_leftover got %0d required 0", exp_q.size()); end
    n_checks++; if (dones != 1) begin n_fail++; $display("FAIL stall_dones got %0d required 1", dones); end
  endtask

  task automatic test_start_while_busy();
    int d;
    fill_mem(1); reset_stats(); bus.out_ready = 1'b1;
    start_frame();
    run_frame(1'b0, 100, d);
    repeat (40) @(negedge clock);
    n_checks++; if (d != 786) begin n_fail++; $display("FAIL restart_done_cycle got %0d required 786", d); end
    n_checks++; if (xfers != 784) begin n_fail++; $display("FAIL restart_xfers got %0d required 784", xfers); end
    n_checks++; if (dones != 1) begin n_fail++; $display("FAIL restart_dones got %0d required 1", dones); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL restart_idle got busy=%b required 0", busy); end
  endtask

  task automatic test_abort();
    int d;
    fill_mem(1); reset_stats(); bus.out_ready = 1'b1;
    start_frame();
    for (int i = 1; i <= 300; i++) @(posedge clock);
    #1 bus.out_ready = 1'b0; abort = 1'b1;
    @(posedge clock); #1 abort = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({bus.out_valid, busy, done} !== 3'b000) begin
      n_fail++; $display("FAIL abort_next got v%b b%b d%b required 000", bus.out_valid, busy, done);
    end
    exp_q.delete();
    repeat (20) @(negedge clock);
    n_checks++; if (xfers != 298) begin n_fail++; $display("FAIL abort_xfers got %0d required 298", xfers); end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL abort_dones got %0d required 0", dones); end
    reset_stats(); bus.out_ready = 1'b1;
    start_frame();
    run_frame(1'b0, -1, d);
    n_checks++; if (first_rel != 2 || d != 786) begin n_fail++; $display("FAIL abort_restart got first=%0d done=%0d required 2 786", first_rel, d); end
    n_checks++; if (xfers != 784) begin n_fail++; $display("FAIL abort_restart_xfers got %0d required 784", xfers); end
  endtask

  task automatic test_reset_midframe();
    int d;
    fill_mem(1); reset_stats(); bus.out_ready = 1'b1;
    start_frame();
    for (int i = 1; i <= 50; i++) @(posedge clock);
    #1;
    n_checks++;
    if (bus.out_row !== 5'd1 || bus.out_col !== 5'd20 || busy !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset got r%0d c%0d b%b required r1 c20 b1", bus.out_row, bus.out_col, busy);
    end
    #1 resetn = 1'b0;
    #1;
    n_checks++;
    if ({bus.out_valid, busy, done, bus.rd_en, bus.rd_addr, bus.out_pixel, bus.out_row, bus.out_col, bus.out_last} !== '0) begin
      n_fail++; $display("FAIL async_reset got v%b b%b r%b a%0d row%0d col%0d required all 0", bus.out_valid, busy, bus.rd_en, bus.rd_addr, bus.out_row, bus.out_col);
    end
    exp_q.delete();
    @(posedge clock); #1 resetn = 1'b1;
    reset_stats();
    start_frame();
    run_frame(1'b0, -1, d);
    n_checks++; if (first_rel != 2 || d != 786) begin n_fail++; $display("FAIL reset_restart got first=%0d done=%0d required 2 786", first_rel, d); end
    n_checks++; if (xfers != 784) begin n_fail++; $display("FAIL reset_restart_xfers got %0d required 784", xfers); end
  endtask

  task automatic test_all_clear();
    int d;
    fill_mem(0); reset_stats(); bus.out_ready = 1'b1;
    start_frame();
    run_frame(1'b0, -1, d);
    n_checks++; if (xfers != 784) begin n_fail++; $display("FAIL clear_xfers got %0d required 784", xfers); end
    n_checks++; if (wraps != 27) begin n_fail++; $display("FAIL clear_wraps got %0d required 27", wraps); end
    n_checks++; if (d != 786) begin n_fail++; $display("FAIL clear_done_cycle got %0d required 786", d); end
  endtask

  initial begin
    bus.out_ready = 1'b1;
    test_reset();
    test_diag_full_rate();
    test_random_stall();
    test_start_while_busy();
    test_abort();
    test_reset_midframe();
    test_all_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
